debug_send_unit: RTL

- Downstream of the debugger step/continue FSM.
- On a one-cycle start_send pulse, it serializes a snapshot frame of pipeline state over the UART transmitter, one byte per TX handshake.
- Frame order: PC, cycle count, all registers, then data-memory words.
- After the last byte is acknowledged, it returns a one-cycle done_send pulse so the FSM can resume stepping.

---
 rtl/debug_send_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/debug_send_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : debug_send_unit
// Brief    : Serializes a PC / cycle-count / register / memory snapshot frame
//            over a byte-wide UART TX handshake, LSB first per word.
// Revision : 1.0 - initial release
// ============================================================================
module debug_send_unit #(
    parameter int NB_DATA     = 32,
    parameter int N_REGS      = 32,
    parameter int N_MEM       = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_MEM_ADDR = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_start_send,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycle_count,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic [7:0]             o_tx_data,
    output logic                   os_tx_start,
    input  logic                   is_tx_done,
    output logic                   os_done_send,
    output logic                   o_busy
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int N_WORDS  = N_REGS + N_MEM + 2;
    localparam int NB_W     = $clog2(N_WORDS);

    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
    localparam logic [NB_W-1:0]    LAST_WORD = NB_W'(N_WORDS - 1);
    localparam logic [NB_W-1:0]    FIRST_REG = NB_W'(2);
    localparam logic [NB_W-1:0]    FIRST_MEM = NB_W'(N_REGS + 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LATCH   = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_TX = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_W-1:0]        word_q, word_d;
    logic [NB_BCNT-1:0]     byte_q, byte_d;
    logic [NB_DATA-1:0]     shift_q, shift_d;
    logic [NB_DATA-1:0]     pc_q, pc_d;
    logic [NB_DATA-1:0]     cc_q, cc_d;
    logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [NB_DATA-1:0]     word_sel;
    logic [NB_W-1:0]        reg_off;
    logic [NB_W-1:0]        mem_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            pc_q       <= '0;
            cc_q       <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            pc_q       <= pc_d;
            cc_q       <= cc_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Register and memory data are live reads; the pipeline is stalled meanwhile.
    always_comb begin
        word_sel = i_mem_data;
        if (word_q == '0) begin
            word_sel = pc_q;
        end else if (word_q == NB_W'(1)) begin
            word_sel = cc_q;
        end else if (word_q < FIRST_MEM) begin
            word_sel = i_reg_data;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        pc_d    = pc_q;
        cc_d    = cc_q;
        case (state_q)
            S_IDLE: begin
                if (is_start_send) begin
                    pc_d    = i_pc;
                    cc_d    = i_cycle_count;
                    word_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                shift_d = word_sel;
                byte_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                if (is_tx_done) begin
                    if (byte_q != LAST_BYTE) begin
                        shift_d = shift_q >> 8;
                        byte_d  = byte_q + NB_BCNT'(1);
                        state_d = S_SEND;
                    end else if (word_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        word_d  = word_q + NB_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses follow the next word index so they are stable throughout FETCH.
    always_comb begin
        reg_off    = word_d - FIRST_REG;
        mem_off    = word_d - FIRST_MEM;
        reg_addr_d = '0;
        mem_addr_d = '0;
        if (word_d >= FIRST_REG && word_d < FIRST_MEM) begin
            reg_addr_d = NB_REG_ADDR'(reg_off);
        end
        if (word_d >= FIRST_MEM) begin
            mem_addr_d = NB_MEM_ADDR'(mem_off);
        end
    end

    assign o_reg_addr   = reg_addr_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_tx_data    = shift_q[7:0];
    assign os_tx_start  = (state_q == S_SEND);
    assign os_done_send = (state_q == S_DONE);
    assign o_busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
